// File: rtl/bus_guard.sv
// Wishbone bus-protection checker plus address-dependent transaction timeout monitor.
// Define BUS_PROTECT_EN to build the restriction checker; otherwise every vcheck simply passes.
module bus_guard #(
    parameter logic [37:0] RESTRICTION0 = 38'b0,
    parameter logic [37:0] RESTRICTION1 = 38'b0,
    parameter logic [37:0] RESTRICTION2 = 38'b0,
    parameter logic [51:0] TOCONF0      = 52'b0,
    parameter logic [51:0] TOCONF1      = 52'b0,
    parameter logic [19:0] TODEFAULT    = 20'b0
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_n_i,
    input  logic        vcheck,
    input  logic [15:0] adr,
    input  logic        wr_en,
    input  logic [3:0]  wbm_id,
    output logic        vpass,
    output logic        vfail,
    output logic [1:0]  viol_idx,
    input  logic        clear,
    output logic        timeout
);

    logic        r_vpass;
    logic        r_vfail;
    logic [1:0]  r_viol_idx;
    logic [19:0] r_count;
    logic [19:0] r_limit;
    logic        r_timeout;
    logic [20:0] w_count_inc;
    logic [19:0] w_lookup;

`ifdef BUS_PROTECT_EN
    logic [2:0] w_hit;
    logic [1:0] w_idx;

    function automatic logic f_hit(input logic [37:0] r, input logic [15:0] a,
                                   input logic we, input logic [3:0] id);
        logic in_range;
        logic denied;
        in_range = (a >= r[37:22]) && (a <= r[21:6]);
        denied   = we ? r[1] : r[0];
        return ((r[5:2] & id) != 4'b0) && in_range && denied;
    endfunction

    assign w_hit[0] = f_hit(RESTRICTION0, adr, wr_en, wbm_id);
    assign w_hit[1] = f_hit(RESTRICTION1, adr, wr_en, wbm_id);
    assign w_hit[2] = f_hit(RESTRICTION2, adr, wr_en, wbm_id);
    assign w_idx    = w_hit[0] ? 2'd0 : (w_hit[1] ? 2'd1 : (w_hit[2] ? 2'd2 : 2'd0));

    // NOTE: async active-low reset in the sensitivity list; all state uses <= so every
    // register samples the pre-edge values of its neighbours.
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            r_vpass    <= 1'b0;
            r_vfail    <= 1'b0;
            r_viol_idx <= 2'd0;
        end else begin
            r_vpass    <= vcheck && (w_hit == 3'b0);
            r_vfail    <= vcheck && (w_hit != 3'b0);
            r_viol_idx <= vcheck ? w_idx : 2'd0;
        end
    end
`else
    logic w_unused_prot;
    assign w_unused_prot = &{1'b0, wr_en, wbm_id};

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            r_vpass <= 1'b0;
        end else begin
            r_vpass <= vcheck;
        end
    end

    assign r_vfail    = 1'b0;
    assign r_viol_idx = 2'd0;
`endif

    assign vpass    = r_vpass;
    assign vfail    = r_vfail;
    assign viol_idx = r_viol_idx;

    // Region 0 beats region 1 beats the default; a zero limit disables a region.
    function automatic logic [19:0] f_lookup(input logic [15:0] a);
        if ((TOCONF0[19:0] != 20'd0) && (a >= TOCONF0[51:36]) && (a <= TOCONF0[35:20]))
            return TOCONF0[19:0];
        else if ((TOCONF1[19:0] != 20'd0) && (a >= TOCONF1[51:36]) && (a <= TOCONF1[35:20]))
            return TOCONF1[19:0];
        else
            return TODEFAULT;
    endfunction

    assign w_lookup    = f_lookup(adr);
    assign w_count_inc = {1'b0, r_count} + 21'd1;

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            r_count   <= 20'd0;
            r_limit   <= TODEFAULT;
            r_timeout <= 1'b0;
        end else if (clear) begin
            r_count   <= 20'd0;
            r_limit   <= w_lookup;
            r_timeout <= 1'b0;
        end else begin
            if (!(&r_count)) begin
                r_count <= w_count_inc[19:0];
            end
            // A saturated count yields 2^20 here, which no 20-bit limit can match.
            if ((r_limit != 20'd0) && (w_count_inc == {1'b0, r_limit})) begin
                r_timeout <= 1'b1;
            end
        end
    end

    assign timeout = r_timeout;

endmodule

// File: tb/tb_bus_guard.sv
// Self-checking bench for bus_guard: directed scenarios plus randomized traffic against a
// rule-table / cycle-counting reference model.
module tb_bus_guard;

    localparam logic [37:0] R0 = {16'h1000, 16'h10FF, 4'b0010, 2'b10};
    localparam logic [51:0] T0 = {16'h2000, 16'h20FF, 20'd5};
    localparam logic [19:0] TD = 20'd10;
`ifdef BUS_PROTECT_EN
    localparam bit PROT = 1'b1;
`else
    localparam bit PROT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        vcheck = 1'b0;
    logic [15:0] adr = 16'h0;
    logic        wr_en = 1'b0;
    logic [3:0]  wbm_id = 4'h0;
    logic        clear = 1'b0;
    logic        vpass;
    logic        vfail;
    logic [1:0]  viol_idx;
    logic        timeout;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        int base;
        int high;
        int mask;
        bit deny_wr;
        bit deny_rd;
    } rule_t;

    typedef struct {
        int base;
        int high;
        int limit;
    } region_t;

    rule_t   rules[3];
    region_t regions[2];

    // Reference-model expectations
    bit e_vpass;
    bit e_vfail;
    int e_idx;
    bit e_to;
    int m_cycles;
    int m_limit;

    always #5 clk = ~clk;

    bus_guard #(
        .RESTRICTION0(R0),
        .RESTRICTION1(38'b0),
        .RESTRICTION2(38'b0),
        .TOCONF0(T0),
        .TOCONF1(52'b0),
        .TODEFAULT(TD)
    ) dut (
        .wb_clk_i(clk),
        .wb_rst_n_i(rst_n),
        .vcheck(vcheck),
        .adr(adr),
        .wr_en(wr_en),
        .wbm_id(wbm_id),
        .vpass(vpass),
        .vfail(vfail),
        .viol_idx(viol_idx),
        .clear(clear),
        .timeout(timeout)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int lookup(input int a);
        foreach (regions[i]) begin
            if (regions[i].limit != 0 && a >= regions[i].base && a <= regions[i].high)
                return regions[i].limit;
        end
        return int'(TD);
    endfunction

    task automatic model_reset();
        e_vpass  = 0;
        e_vfail  = 0;
        e_idx    = 0;
        e_to     = 0;
        m_cycles = 0;
        m_limit  = int'(TD);
    endtask

    // Applies one clock edge worth of rules to the model using the currently driven inputs.
    task automatic model_edge();
        bit fail;
        int idx;
        fail = 0;
        idx  = 0;
        for (int k = 0; k < 3; k++) begin
            bit denied;
            denied = wr_en ? rules[k].deny_wr : rules[k].deny_rd;
            if (!fail && (rules[k].mask & int'(wbm_id)) != 0 &&
                int'(adr) >= rules[k].base && int'(adr) <= rules[k].high && denied) begin
                fail = 1;
                idx  = k;
            end
        end
        if (!PROT) begin
            fail = 0;
            idx  = 0;
        end
        e_vpass = vcheck && !fail;
        e_vfail = vcheck && fail;
        e_idx   = vcheck ? idx : 0;
        if (clear) begin
            m_cycles = 0;
            m_limit  = lookup(int'(adr));
            e_to     = 0;
        end else begin
            m_cycles++;
            if (m_limit != 0 && m_cycles >= m_limit) e_to = 1;
        end
    endtask

    task automatic check_all(input string ph);
        check({ph, "_vpass"}, vpass, e_vpass);
        check({ph, "_vfail"}, vfail, e_vfail);
        check({ph, "_viol_idx"}, viol_idx, e_idx);
        check({ph, "_timeout"}, timeout, e_to);
    endtask

    task automatic cycle(input string ph, input bit vc, input logic [15:0] a, input bit we,
                         input logic [3:0] id, input bit clr);
        vcheck = vc;
        adr    = a;
        wr_en  = we;
        wbm_id = id;
        clear  = clr;
        @(posedge clk);
        model_edge();
        #1;
        check_all(ph);
    endtask

    int addrs[10] = '{'h1000, 'h10FF, 'h1080, 'h0FFF, 'h1100, 'h2000, 'h20FF, 'h2100, 'h3000, 'h2010};

    initial begin
        rules[0]   = '{'h1000, 'h10FF, 'b0010, 1'b1, 1'b0};
        rules[1]   = '{0, 0, 0, 1'b0, 1'b0};
        rules[2]   = '{0, 0, 0, 1'b0, 1'b0};
        regions[0] = '{'h2000, 'h20FF, 5};
        regions[1] = '{0, 0, 0};
        model_reset();

        #12;
        check_all("reset");
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Write denied / read allowed / other master
        cycle("s1", 1, 16'h1080, 1, 4'b0010, 1);
        check("s1_vfail_const", vfail, PROT);
        check("s1_vpass_const", vpass, !PROT);
        cycle("s2_read", 1, 16'h1080, 0, 4'b0010, 1);
        check("s2_read_vpass_const", vpass, 1);
        cycle("s2_master0", 1, 16'h1080, 1, 4'b0001, 1);
        check("s2_master0_vpass_const", vpass, 1);

        // Range boundaries, back to back
        cycle("s3_hi", 1, 16'h10FF, 1, 4'b0010, 1);
        check("s3_hi_vfail_const", vfail, PROT);
        cycle("s3_above", 1, 16'h1100, 1, 4'b0010, 1);
        check("s3_above_vpass_const", vpass, 1);
        cycle("s3_below", 1, 16'h0FFF, 1, 4'b0010, 1);
        check("s3_below_vpass_const", vpass, 1);
        cycle("s3_idle", 0, 16'h1080, 1, 4'b0010, 1);
        check("s3_idle_vpass_const", vpass, 0);

        // Region timeout of 5; later adr changes must not alter the frozen limit
        cycle("s4_clr", 0, 16'h2010, 0, 4'b0, 1);
        for (int i = 1; i <= 8; i++) begin
            cycle("s4_run", 0, 16'h3000, 0, 4'b0, 0);
            check("s4_timeout_const", timeout, i >= 5);
        end
        cycle("s4_reclear", 0, 16'h3000, 0, 4'b0, 1);
        check("s4_reclear_const", timeout, 0);

        // Default timeout of 10, then re-clear at edge 9
        for (int i = 1; i <= 10; i++) begin
            cycle("s5_run", 0, 16'h3000, 0, 4'b0, 0);
            check("s5_timeout_const", timeout, i == 10);
        end
        cycle("s5_clr", 0, 16'h3000, 0, 4'b0, 1);
        for (int i = 1; i <= 8; i++) cycle("s5_pre", 0, 16'h3000, 0, 4'b0, 0);
        cycle("s5_edge9", 0, 16'h3000, 0, 4'b0, 1);
        check("s5_edge9_const", timeout, 0);
        for (int i = 1; i <= 9; i++) cycle("s5_post", 0, 16'h3000, 0, 4'b0, 0);
        check("s5_post_const", timeout, 0);

        // Async reset right after a vcheck with timeout set
        cycle("s6_to", 0, 16'h3000, 0, 4'b0, 0);
        check("s6_to_const", timeout, 1);
        cycle("s6_vc", 1, 16'h1080, 1, 4'b0010, 0);
        check("s6_vc_const", vpass | vfail, 1);
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("s6_async");
        vcheck = 1'b0;
        @(posedge clk);
        #1;
        check_all("s6_held");
        rst_n = 1'b1;

        // Randomized traffic
        cycle("rnd_init", 0, 16'h3000, 0, 4'b0, 1);
        for (int i = 0; i < 400; i++) begin
            logic [15:0] a;
            if ($urandom_range(0, 4) == 0) a = 16'($urandom);
            else a = 16'(addrs[$urandom_range(0, 9)]);
            cycle("rnd", 1'($urandom_range(0, 1)), a, 1'($urandom_range(0, 1)),
                  4'($urandom_range(0, 15)), $urandom_range(0, 11) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
